ulbf_coeffs_axis_master: RTL and testbench

//  Coefficient streaming master; one instance per coefficient BRAM (8 per ulbf_coeffs).

---
 rtl/ulbf_coeffs_axis_master.sv | 224 ++++++++++++++++++++++
 tb/tb_ulbf_coeffs_axis_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ulbf_coeffs_axis_master.sv
// Coefficient streaming master: reads coefficient RAM port B and emits an AXI4-Stream with tlast per block.
// Optional start-of-block tuser output enabled by defining ULBF_COEFFS_SOB_EN.
module ulbf_coeffs_axis_master #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              m_axis_clk,
  input  logic              m_axis_rst_n,
  input  logic              soft_rst,
  input  logic              go,
  input  logic [11:0]       block_size,
  input  logic [11:0]       niter,
  input  logic [15:0]       rollover_addr,
  output logic [15:0]       addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
`ifdef ULBF_COEFFS_SOB_EN
  output logic              m_axis_tuser,
`endif
  output logic              done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned CFG_W = 12;
  localparam int unsigned ADR_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_n;
  logic               go_d;
  logic [CFG_W-1:0]   bs_q, ni_q, beat_cnt, blk_cnt;
  logic [ADR_W-1:0]   roll_q;
  logic               iss_last_q;
  logic [RAM_LATENCY-1:0] vld_sr, last_sr;
  logic [CNT_W-1:0]   inflight, fifo_cnt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [DATA_W-1:0]  data_mem [FIFO_DEPTH];
  logic               last_mem [FIFO_DEPTH];

  logic               start_c, pop_c, push_c, room_c, issue_c, blk_end_c, run_end_c;
  logic [CFG_W-1:0]   cfg_bs_c, cfg_ni_c;
  logic [SUM_W-1:0]   occ_c;
  logic [ADR_W-1:0]   next_addr_c;

`ifdef ULBF_COEFFS_SOB_EN
  logic                   iss_user_q;
  logic [RAM_LATENCY-1:0] user_sr;
  logic                   user_mem [FIFO_DEPTH];
`endif

  // Issue-side decode; config comes straight from the CSR inputs on the start cycle
  always_comb begin
    start_c     = go & ~go_d;
    cfg_bs_c    = (state_q == S_IDLE) ? block_size : bs_q;
    cfg_ni_c    = (state_q == S_IDLE) ? niter : ni_q;
    pop_c       = m_axis_tvalid & m_axis_tready;
    push_c      = vld_sr[RAM_LATENCY-1];
    occ_c       = SUM_W'(fifo_cnt) + SUM_W'(inflight) - SUM_W'(pop_c);
    room_c      = occ_c < SUM_W'(FIFO_DEPTH);
    blk_end_c   = (beat_cnt == cfg_bs_c - 12'd1);
    run_end_c   = blk_end_c && (blk_cnt == cfg_ni_c - 12'd1);
    next_addr_c = (addrb == roll_q - 16'd1) ? '0 : addrb + 16'd1;
  end

  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) state_q <= S_IDLE;
    else               state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    issue_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if (block_size == '0 || niter == '0) begin
            state_n = S_DONE;
          end else begin
            issue_c = 1'b1;
            state_n = run_end_c ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (room_c) begin
          issue_c = 1'b1;
          if (run_end_c) state_n = S_DRAIN;
        end
      end
      S_DRAIN: if (inflight == '0 && fifo_cnt == '0) state_n = S_DONE;
      S_DONE:  if (!go) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (soft_rst) begin
      state_n = S_IDLE;
      issue_c = 1'b0;
    end
  end

  // go edge detector keeps tracking through soft reset so a held go never restarts
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      go_d <= 1'b0;
      done <= 1'b0;
    end else begin
      go_d <= go;
      done <= (state_n == S_DONE);
    end
  end

  // Read issue: enb/addrb are registered one cycle after the issue decision
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      enb        <= 1'b0;
      addrb      <= '0;
      iss_last_q <= 1'b0;
      bs_q       <= '0;
      ni_q       <= '0;
      roll_q     <= '0;
      beat_cnt   <= '0;
      blk_cnt    <= '0;
      inflight   <= '0;
      vld_sr     <= '0;
      last_sr    <= '0;
    end else if (soft_rst) begin
      enb        <= 1'b0;
      addrb      <= '0;
      iss_last_q <= 1'b0;
      beat_cnt   <= '0;
      blk_cnt    <= '0;
      inflight   <= '0;
      vld_sr     <= '0;
      last_sr    <= '0;
    end else begin
      enb        <= issue_c;
      iss_last_q <= blk_end_c;
      if (state_q == S_IDLE && start_c) begin
        bs_q   <= block_size;
        ni_q   <= niter;
        roll_q <= rollover_addr;
        addrb  <= '0;
      end else if (enb) begin
        addrb <= next_addr_c;
      end
      if (issue_c) begin
        if (blk_end_c) begin
          beat_cnt <= '0;
          blk_cnt  <= blk_cnt + 12'd1;
        end else begin
          beat_cnt <= beat_cnt + 12'd1;
        end
      end else if (state_q == S_IDLE || state_q == S_DONE) begin
        beat_cnt <= '0;
        blk_cnt  <= '0;
      end
      inflight   <= inflight + CNT_W'(issue_c) - CNT_W'(push_c);
      vld_sr[0]  <= enb;
      last_sr[0] <= iss_last_q;
      for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  // Skid FIFO pointers; credit accounting guarantees it never overflows
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (soft_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_c) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge m_axis_clk) begin
    if (push_c) begin
      data_mem[wr_ptr] <= doutb;
      last_mem[wr_ptr] <= last_sr[RAM_LATENCY-1];
    end
  end

  assign m_axis_tvalid = (fifo_cnt != '0);
  assign m_axis_tdata  = data_mem[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid & last_mem[rd_ptr];

`ifdef ULBF_COEFFS_SOB_EN
  // Start-of-block flag follows the same issue-to-FIFO path as tlast
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      iss_user_q <= 1'b0;
      user_sr    <= '0;
    end else if (soft_rst) begin
      iss_user_q <= 1'b0;
      user_sr    <= '0;
    end else begin
      iss_user_q <= (beat_cnt == '0);
      user_sr[0] <= iss_user_q;
      for (int unsigned i = 1; i < RAM_LATENCY; i++) user_sr[i] <= user_sr[i-1];
    end
  end

  always_ff @(posedge m_axis_clk) begin
    if (push_c) user_mem[wr_ptr] <= user_sr[RAM_LATENCY-1];
  end

  assign m_axis_tuser = m_axis_tvalid & user_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_ulbf_coeffs_axis_master.sv
// Directed/randomized bench for ulbf_coeffs_axis_master against an address/beat reference model.
module tb_ulbf_coeffs_axis_master;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned RAM_L  = 2;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              soft_rst = 1'b0;
  logic              go = 1'b0;
  logic [11:0]       block_size = '0, niter = '0;
  logic [15:0]       rollover_addr = '0;
  logic [15:0]       addrb;
  logic              enb;
  logic [DATA_W-1:0] doutb;
  logic [DATA_W-1:0] tdata;
  logic              tvalid, tlast, done;
  logic              tready = 1'b0;
`ifdef ULBF_COEFFS_SOB_EN
  logic              tuser;
`endif

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [31:0] seed [4];
  logic [DATA_W-1:0] rpipe [RAM_L];

  always #5 clk = ~clk;

  ulbf_coeffs_axis_master #(.DATA_W(DATA_W), .RAM_LATENCY(RAM_L), .FIFO_DEPTH(DEPTH)) dut (
    .m_axis_clk(clk), .m_axis_rst_n(rst_n), .soft_rst(soft_rst), .go(go),
    .block_size(block_size), .niter(niter), .rollover_addr(rollover_addr),
    .addrb(addrb), .enb(enb), .doutb(doutb),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
`ifdef ULBF_COEFFS_SOB_EN
    .m_axis_tuser(tuser),
`endif
    .done(done));

  function automatic logic [DATA_W-1:0] ram_word(input logic [15:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return {(a32 * 32'h9E37_79B1) ^ seed[0], a32 + seed[1], ~a32 ^ seed[2], a32 ^ seed[3]};
  endfunction

  // RAM model: doutb valid RAM_L cycles after enb/addrb
  always @(posedge clk) begin
    rpipe[0] <= enb ? ram_word(addrb) : '0;
    for (int i = 1; i < RAM_L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign doutb = rpipe[RAM_L-1];

  function automatic logic [15:0] exp_addr(input int unsigned k, input int unsigned roll);
    return (roll == 0) ? 16'(k % 65536) : 16'(k % roll);
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: go edge, then per-cycle RAM-address and stream checks against the model
  task automatic do_run(input int unsigned bs, input int unsigned ni, input int unsigned roll,
                        input int unsigned pct, input bit chk_lat, input int unsigned abort_at);
    int unsigned total, issued, got, n;
    bit stall_prev, seen_enb, seen_beat, aborted;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;
    total = bs * ni; issued = 0; got = 0; n = 0;
    stall_prev = 0; seen_enb = 0; seen_beat = 0; aborted = 0;
    prev_data = '0; prev_last = 0;
    @(negedge clk);
    block_size = 12'(bs); niter = 12'(ni); rollover_addr = 16'(roll); go = 1'b1;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      tready = ($urandom_range(99) < pct);
      if (n > 1) begin
        block_size = 12'($urandom); niter = 12'($urandom); rollover_addr = 16'($urandom);
      end
      if (enb) begin
        chk("ram_addr", DATA_W'(addrb), DATA_W'(exp_addr(issued, roll)));
        if (chk_lat && !seen_enb) chk("enb_latency", DATA_W'(n), DATA_W'(1));
        seen_enb = 1; issued++;
      end
      if (stall_prev) begin
        chk("hold_valid", DATA_W'(tvalid), DATA_W'(1));
        chk("hold_data", tdata, prev_data);
        chk("hold_last", DATA_W'(tlast), DATA_W'(prev_last));
      end
      if (pct == 100 && seen_beat && got < total) chk("no_bubble", DATA_W'(tvalid), DATA_W'(1));
      if (tvalid && tready) begin
        if (chk_lat && !seen_beat) chk("tvalid_latency", DATA_W'(n), DATA_W'(RAM_L + 2));
        chk("tdata", tdata, ram_word(exp_addr(got, roll)));
        chk("tlast", DATA_W'(tlast), DATA_W'((got % bs) == bs - 1));
`ifdef ULBF_COEFFS_SOB_EN
        chk("tuser", DATA_W'(tuser), DATA_W'((got % bs) == 0));
`endif
        seen_beat = 1; got++;
        if (abort_at != 0 && got == abort_at) begin
          soft_rst = 1'b1; aborted = 1;
          break;
        end
      end
      stall_prev = tvalid && !tready;
      prev_data = tdata; prev_last = tlast;
      if (done) break;
    end
    tready = 1'b0;
    if (!aborted) begin
      chk("run_done", DATA_W'(done), DATA_W'(1));
      chk("beats", DATA_W'(got), DATA_W'(total));
      chk("reads", DATA_W'(issued), DATA_W'(total));
      chk("final_addrb", DATA_W'(addrb), DATA_W'(exp_addr(total, roll)));
      chk("tvalid_after", DATA_W'(tvalid), DATA_W'(0));
    end
  endtask

  task automatic go_low;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("done_clear", DATA_W'(done), DATA_W'(0));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) seed[i] = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_addrb", DATA_W'(addrb), '0);
    chk("rst_enb", DATA_W'(enb), '0);
    chk("rst_tvalid", DATA_W'(tvalid), '0);
    chk("rst_tlast", DATA_W'(tlast), '0);
    chk("rst_done", DATA_W'(done), '0);
    rst_n = 1'b1;

    // Basic run with latency checks, then wrap at 6 with tready held high
    do_run(4, 2, 1024, 100, 1'b1, 0);
    go_low();
    do_run(4, 3, 6, 100, 1'b0, 0);
    go_low();

    // Random back-pressure
    do_run(16, 4, 1024, 50, 1'b0, 0);
    go_low();

    // Soft reset mid-run, then a clean restart from address 0
    do_run(16, 4, 1024, 100, 1'b0, 3);
    @(negedge clk);
    chk("srst_tvalid", DATA_W'(tvalid), '0);
    chk("srst_done", DATA_W'(done), '0);
    chk("srst_addrb", DATA_W'(addrb), '0);
    chk("srst_enb", DATA_W'(enb), '0);
    soft_rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("srst_no_restart", DATA_W'(enb | tvalid), '0);
    end
    go_low();
    do_run(4, 2, 1024, 100, 1'b1, 0);

    // go held high after done must not restart
    repeat (8) begin
      @(negedge clk);
      chk("held_done", DATA_W'(done), DATA_W'(1));
      chk("held_idle", DATA_W'(enb | tvalid), '0);
    end
    go_low();
    do_run(4, 2, 1024, 100, 1'b1, 0);
    go_low();

    // niter=0: immediate done, nothing issued
    @(negedge clk);
    block_size = 12'd4; niter = 12'd0; rollover_addr = 16'd16; go = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      chk("zero_enb", DATA_W'(enb), '0);
      chk("zero_tvalid", DATA_W'(tvalid), '0);
      if (n == 2) chk("zero_done", DATA_W'(done), DATA_W'(1));
    end
    go_low();

    // Edge and random configurations
    do_run(1, 1, 0, 100, 1'b0, 0);
    go_low();
    do_run(3, 2, 0, 70, 1'b0, 0);
    go_low();
    for (int r = 0; r < 6; r++) begin
      do_run($urandom_range(7, 1), $urandom_range(5, 1),
             ($urandom_range(3) == 0) ? 0 : $urandom_range(40, 1), $urandom_range(100, 30), 1'b0, 0);
      go_low();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
